// File: rtl/regfile_ctrl_pkg.sv
// Shared widths and types for the register-file writeback arbiter and its scoreboard.
package regfile_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Wide enough for the largest legal STARVE_LIMIT (15).
  localparam int STARVE_W   = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xdata_t;
  typedef logic [NUM_REGS-1:0]   reg_vec_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_ALU,
    GRANT_LSU
  } grant_e;

  typedef struct packed {
    logic      en;
    reg_addr_t rd;
    xdata_t    data;
  } wb_t;

  // One-hot select of a register; x0 never appears in any mask.
  function automatic reg_vec_t rd_mask(input reg_addr_t rd);
    reg_vec_t m;
    m = '0;
    if (rd != '0) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set on load issue,
// cleared on load return, with a combinational source-operand hazard lookup.
module regfile_scoreboard
  import regfile_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  hazard
);

  reg_vec_t set_mask;
  reg_vec_t clr_mask;
  reg_vec_t busy_next;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    if (set_en) set_mask = rd_mask(set_rd);
    if (clr_en) clr_mask = rd_mask(clr_rd);
    // Clear first, then set: a same-cycle return and re-issue leaves the bit set.
    busy_next = (busy & ~clr_mask) | set_mask;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // The busy vector is plain flops with reset, not a RAM: it must clear in one cycle.
  always_ff @(posedge clock) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

  always_comb begin
    hazard = 1'b0;
    if (chk_rs1 != '0 && busy[chk_rs1]) hazard = 1'b1;
    if (chk_rs2 != '0 && busy[chk_rs2]) hazard = 1'b1;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter (ALU priority, LSU anti-starvation) driving the
// register-file write port through a one-cycle output register.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  output logic                  hazard,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_addr_rd,
  output logic [XLEN-1:0]       rf_data_rd,
  output logic [NUM_REGS-1:0]   busy
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic                lsu_priority;
  grant_e              grant;
  logic                lsu_xfer;
  logic                issue_xfer;
  logic                rd_returning;
  wb_t                 wb_q;

  assign lsu_priority = (starve_cnt == LIMIT);

  // Readies look only at valids and starvation state, never at the payloads.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    grant     = GRANT_NONE;
    if (reset) begin
      lsu_ready = !alu_valid || lsu_priority;
      alu_ready = !(lsu_valid && lsu_priority);
      if (lsu_valid && lsu_ready)      grant = GRANT_LSU;
      else if (alu_valid && alu_ready) grant = GRANT_ALU;
    end
  end

  assign lsu_xfer = (grant == GRANT_LSU);

  // A load may re-claim a busy rd only if that rd is being returned this cycle.
  assign rd_returning = lsu_xfer && (lsu_rd == issue_rd);
  assign issue_ready  = reset && !(busy[issue_rd] && !rd_returning);
  assign issue_xfer   = issue_valid && issue_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!lsu_valid || lsu_xfer) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // rd=0 transfers complete but never write; address/data keep their last value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wb_q <= '0;
    end else begin
      wb_q.en <= 1'b0;
      case (grant)
        GRANT_ALU: begin
          if (alu_rd != '0) begin
            wb_q.en   <= 1'b1;
            wb_q.rd   <= alu_rd;
            wb_q.data <= alu_data;
          end
        end
        GRANT_LSU: begin
          if (lsu_rd != '0) begin
            wb_q.en   <= 1'b1;
            wb_q.rd   <= lsu_rd;
            wb_q.data <= lsu_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign rf_write_enable = wb_q.en;
  assign rf_addr_rd      = wb_q.rd;
  assign rf_data_rd      = wb_q.data;

  regfile_scoreboard u_scoreboard (
    .clock   (clock),
    .reset   (reset),
    .set_en  (issue_xfer),
    .set_rd  (issue_rd),
    .clr_en  (lsu_xfer),
    .clr_rd  (lsu_rd),
    .chk_rs1 (chk_rs1),
    .chk_rs2 (chk_rs2),
    .busy    (busy),
    .hazard  (hazard)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs1, chk_rs2;
  logic        hazard;
  logic        rf_write_enable;
  logic [4:0]  rf_addr_rd;
  logic [31:0] rf_data_rd;
  logic [31:0] busy;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .lsu_valid       (lsu_valid),
    .lsu_ready       (lsu_ready),
    .lsu_rd          (lsu_rd),
    .lsu_data        (lsu_data),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_rd        (issue_rd),
    .chk_rs1         (chk_rs1),
    .chk_rs2         (chk_rs2),
    .hazard          (hazard),
    .rf_write_enable (rf_write_enable),
    .rf_addr_rd      (rf_addr_rd),
    .rf_data_rd      (rf_data_rd),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_ar;
    logic        e_lr;
    logic        e_ir;
    logic        e_hz;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0;
  endtask

  initial begin
    // Fields: alu v/rd/data, lsu v/rd/data, issue v/rd, rs1, rs2 |
    //         alu_ready, lsu_ready, issue_ready, hazard | we, addr, data, busy (after edge)
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0,  0, 0,  1, 0, 1, 0,  1, 5,  32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 0, 0,            1, 3, 32'h11111111, 0, 0,  0, 0,  1, 1, 1, 0,  1, 3,  32'h11111111, 32'h0};
    vecs[2]  = '{0, 0, 0,            0, 0, 0,            1, 7,  0, 0,  1, 1, 1, 0,  0, 3,  32'h11111111, 32'h80};
    vecs[3]  = '{0, 0, 0,            0, 0, 0,            1, 7,  7, 0,  1, 1, 0, 1,  0, 3,  32'h11111111, 32'h80};
    vecs[4]  = '{0, 0, 0,            1, 7, 32'hCAFEF00D, 0, 0,  7, 0,  1, 1, 1, 1,  1, 7,  32'hCAFEF00D, 32'h0};
    vecs[5]  = '{0, 0, 0,            0, 0, 0,            0, 0,  7, 0,  1, 1, 1, 0,  0, 7,  32'hCAFEF00D, 32'h0};
    vecs[6]  = '{1, 0, 32'h1234,     0, 0, 0,            1, 0,  0, 0,  1, 0, 1, 0,  0, 7,  32'hCAFEF00D, 32'h0};
    vecs[7]  = '{0, 0, 0,            0, 0, 0,            1, 9,  0, 0,  1, 1, 1, 0,  0, 7,  32'hCAFEF00D, 32'h200};
    vecs[8]  = '{0, 0, 0,            1, 9, 32'h99,       1, 9,  0, 9,  1, 1, 1, 1,  1, 9,  32'h99,       32'h200};
    vecs[9]  = '{0, 0, 0,            0, 0, 0,            1, 10, 9, 10, 1, 1, 1, 1,  0, 9,  32'h99,       32'h600};
    vecs[10] = '{0, 0, 0,            1, 10, 32'hA,       1, 9,  0, 0,  1, 1, 0, 0,  1, 10, 32'hA,        32'h200};

    // Reset state, with an ALU request present to show readies are forced low.
    reset = 0;
    idle();
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h4;
    tick();
    tick();
    check("reset alu_ready", alu_ready, 0);
    check("reset lsu_ready", lsu_ready, 0);
    check("reset issue_ready", issue_ready, 0);
    check("reset we", rf_write_enable, 0);
    check("reset addr", rf_addr_rd, 0);
    check("reset data", rf_data_rd, 0);
    check("reset busy", busy, 0);
    idle();
    reset = 1;

    for (int i = 0; i < 11; i++) begin
      alu_valid   = vecs[i].av;  alu_rd = vecs[i].ard; alu_data = vecs[i].adata;
      lsu_valid   = vecs[i].lv;  lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ldata;
      issue_valid = vecs[i].iv;  issue_rd = vecs[i].ird;
      chk_rs1     = vecs[i].rs1; chk_rs2 = vecs[i].rs2;
      #1;
      check($sformatf("v%0d alu_ready", i), alu_ready, vecs[i].e_ar);
      check($sformatf("v%0d lsu_ready", i), lsu_ready, vecs[i].e_lr);
      check($sformatf("v%0d issue_ready", i), issue_ready, vecs[i].e_ir);
      check($sformatf("v%0d hazard", i), hazard, vecs[i].e_hz);
      tick();
      check($sformatf("v%0d we", i), rf_write_enable, vecs[i].e_we);
      check($sformatf("v%0d addr", i), rf_addr_rd, vecs[i].e_addr);
      check($sformatf("v%0d data", i), rf_data_rd, vecs[i].e_data);
      check($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
    end

    // Starvation: both valid throughout; LSU wins on the 5th cycle, the counter
    // restarts, and a cycle with lsu_valid low also restarts it.
    idle();
    for (int i = 0; i < 13; i++) begin
      logic exp_lr;
      alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h100 + i;
      lsu_valid = (i != 7); lsu_rd = 5'd2; lsu_data = 32'h55;
      exp_lr = (i == 4 || i == 12);
      #1;
      check($sformatf("starve%0d lsu_ready", i), lsu_ready, exp_lr);
      check($sformatf("starve%0d alu_ready", i), alu_ready, !exp_lr);
      tick();
      check($sformatf("starve%0d we", i), rf_write_enable, 1);
      check($sformatf("starve%0d addr", i), rf_addr_rd, exp_lr ? 5'd2 : 5'd1);
      check($sformatf("starve%0d data", i), rf_data_rd, exp_lr ? 32'h55 : 32'h100 + i);
    end

    // Build busy = 0x480 (x7, x10), then assert reset with traffic pending.
    idle();
    lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h9;
    issue_valid = 1; issue_rd = 5'd7;
    tick();
    idle();
    issue_valid = 1; issue_rd = 5'd10;
    tick();
    check("pre-reset busy", busy, 32'h480);
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h44;
    lsu_valid = 1; lsu_rd = 5'd5; lsu_data = 32'h55;
    issue_valid = 1; issue_rd = 5'd3;
    chk_rs1 = 5'd7;
    reset = 0;
    #1;
    check("midreset alu_ready", alu_ready, 0);
    check("midreset lsu_ready", lsu_ready, 0);
    check("midreset issue_ready", issue_ready, 0);
    tick();
    check("midreset busy", busy, 0);
    check("midreset we", rf_write_enable, 0);
    check("midreset addr", rf_addr_rd, 0);
    check("midreset data", rf_data_rd, 0);
    check("midreset hazard", hazard, 0);

    // Release reset: the held ALU request goes through with latency 1.
    lsu_valid = 0; issue_valid = 0;
    reset = 1;
    #1;
    check("postreset alu_ready", alu_ready, 1);
    tick();
    check("postreset we", rf_write_enable, 1);
    check("postreset addr", rf_addr_rd, 5'd4);
    check("postreset data", rf_data_rd, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
